// File: rtl/arm_instr_encoder.sv
// Packs field-level ARM instruction descriptors into 32-bit words and streams
// them through a small FIFO into instruction memory at incrementing addresses.
module arm_instr_encoder #(
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [3:0]    in_cond,
  input  logic [5:0]    in_funct,
  input  logic [3:0]    in_rn,
  input  logic [3:0]    in_rd,
  input  logic [11:0]   in_src2,
  input  logic [23:0]   in_imm24,
  input  logic          in_last,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [15:0]   words_written,
  output logic          err_sticky,
  output logic          done
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 33;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic [31:0]   word_c;
  logic          full, empty, legal, accept, push, pop, restart;

  assign restart  = !reset || clear;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign legal    = (in_op != 2'b11);
  assign in_ready = (state == LOAD) && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign head     = mem[rd_ptr];
  assign wr_valid = !empty && (state != DONE);
  assign wr_data  = head[31:0];
  assign pop      = wr_valid && wr_ready;
  assign done     = (state == DONE);

  // Field packing mirrors the decoder's Op/Funct/Rn/Rd/Src2 split; branches carry imm24.
  always_comb begin
    word_c = '0;
    case (in_op)
      2'b10:   word_c = {in_cond, 2'b10, 1'b1, in_funct[4], in_imm24};
      default: word_c = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
    endcase
  end

  // Entry storage: {last, word}; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, word_c};
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      wr_addr       <= BASE_ADDR;
      words_written <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (pop) begin
        wr_addr <= wr_addr + AW'(4);
        if (words_written != 16'hFFFF) words_written <= words_written + 16'd1;
      end
      if (accept && !legal) err_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (restart) state <= LOAD;
    else         state <= state_nx;
  end

  // Program end is marked by the last flag travelling with its word through the FIFO.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (push && in_last) state_nx = DRAIN;
      DRAIN:   if (pop && head[EW-1]) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = LOAD;
    endcase
  end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed bench for arm_instr_encoder: encoding, ordering, backpressure,
// illegal descriptors, clear, and address wrap on a narrow-address instance.
module tb_arm_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic        in_valid, in_ready, in_last;
  logic [1:0]  in_op;
  logic [3:0]  in_cond, in_rn, in_rd;
  logic [5:0]  in_funct;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] words_written;
  logic        err_sticky, done;

  logic        w_in_ready, w_wr_valid, w_err, w_done;
  logic [7:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [15:0] w_words;

  int checks = 0;
  int errors = 0;
  logic [63:0] wlog[$];
  logic [63:0] wlog_w[$];

  always #5 clk = ~clk;

  arm_instr_encoder u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cond(in_cond),
    .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .words_written(words_written), .err_sticky(err_sticky), .done(done)
  );

  arm_instr_encoder #(.DEPTH(2), .AW(8), .BASE_ADDR(8'hFC)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_op(in_op), .in_cond(in_cond),
    .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .in_last(in_last),
    .wr_valid(w_wr_valid), .wr_ready(wr_ready), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .words_written(w_words), .err_sticky(w_err), .done(w_done)
  );

  // Record every imem write handshake that will complete at the next rising edge.
  always @(negedge clk) begin
    if (reset && !clear) begin
      if (wr_valid && wr_ready)     wlog.push_back({wr_addr, wr_data});
      if (w_wr_valid && wr_ready)   wlog_w.push_back({24'h0, w_wr_addr, w_wr_data});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_desc(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rn,
                          input logic [3:0] rd, input logic [11:0] src2,
                          input logic [23:0] imm, input logic last);
    in_op = op; in_cond = 4'hE; in_funct = funct; in_rn = rn; in_rd = rd;
    in_src2 = src2; in_imm24 = imm; in_last = last;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rn,
                      input logic [3:0] rd, input logic [11:0] src2,
                      input logic [23:0] imm, input logic last);
    int n;
    n = 0;
    set_desc(op, funct, rn, rd, src2, imm, last);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wlog.delete();
    wlog_w.delete();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_done", 64'(done), 64'd1);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    set_desc(2'b00, 6'h0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // ADD R1,R2,#5
    wr_ready = 1'b1;
    send(2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0);
    check("add_valid", 64'(wr_valid), 64'd1);
    check("add_data", 64'(wr_data), 64'hE2821005);
    check("add_addr", 64'(wr_addr), 64'h0);
    @(posedge clk); #1;
    check("add_words", 64'(words_written), 64'd1);
    check("add_addr_next", 64'(wr_addr), 64'h4);
    check("add_empty", 64'(wr_valid), 64'd0);

    // LDR R3,[R4,#8] then BL +0x10 (last)
    do_clear();
    send(2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b0);
    send(2'b10, 6'b010000, 4'd0, 4'd0, 12'h000, 24'h000010, 1'b1);
    check("bl_data", 64'(wr_data), 64'hEB000010);
    check("bl_addr", 64'(wr_addr), 64'h4);
    check("drain_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("prog_done", 64'(done), 64'd1);
    check("done_in_ready", 64'(in_ready), 64'd0);
    check("done_wr_valid", 64'(wr_valid), 64'd0);
    check("prog_words", 64'(words_written), 64'd2);
    check("prog_nlog", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("prog_w0", wlog[0], {32'h0, 32'hE5943008});
      check("prog_w1", wlog[1], {32'h4, 32'hEB000010});
    end

    // Backpressure: five back-to-back offers into a four-entry FIFO
    do_clear();
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_desc(2'b00, 6'h0, 4'h0, 4'h0, 12'(i), 24'h0, 1'b0);
      in_valid = 1'b1;
      check("bp_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    check("bp_head_data", 64'(wr_data), 64'hE0000000);
    wr_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 20 && wlog.size() < 5; n++) begin
      @(posedge clk); #1;
    end
    check("bp_nlog", 64'(wlog.size()), 64'd5);
    if (wlog.size() == 5) begin
      for (int i = 0; i < 5; i++)
        check("bp_word", wlog[i], {32'(4 * i), 32'hE0000000 | 32'(i)});
    end
    check("bp_words", 64'(words_written), 64'd5);

    // Illegal descriptor between two legal words (its last flag must be ignored)
    do_clear();
    send(2'b00, 6'h0, 4'h0, 4'h0, 12'h011, 24'h0, 1'b0);
    check("ill_err_before", 64'(err_sticky), 64'd0);
    send(2'b11, 6'h0, 4'h0, 4'h0, 12'h0FF, 24'h0, 1'b1);
    check("ill_err", 64'(err_sticky), 64'd1);
    check("ill_still_load", 64'(in_ready), 64'd1);
    send(2'b00, 6'h0, 4'h0, 4'h0, 12'h022, 24'h0, 1'b1);
    wait_done();
    check("ill_words", 64'(words_written), 64'd2);
    check("ill_nlog", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("ill_w0", wlog[0], {32'h0, 32'hE0000011});
      check("ill_w1", wlog[1], {32'h4, 32'hE0000022});
    end

    // Clear with three words queued and imem stalled
    do_clear();
    send(2'b11, 6'h0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0);
    send(2'b00, 6'h0, 4'h0, 4'h0, 12'h033, 24'h0, 1'b0);
    @(posedge clk); #1;
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b00, 6'h0, 4'h0, 4'h0, 12'(i), 24'h0, 1'b0);
    check("clr_pre_valid", 64'(wr_valid), 64'd1);
    check("clr_pre_words", 64'(words_written), 64'd1);
    check("clr_pre_err", 64'(err_sticky), 64'd1);
    check("clr_pre_addr", 64'(wr_addr), 64'h4);
    do_clear();
    check("clr_wr_valid", 64'(wr_valid), 64'd0);
    check("clr_wr_addr", 64'(wr_addr), 64'h0);
    check("clr_words", 64'(words_written), 64'd0);
    check("clr_err", 64'(err_sticky), 64'd0);
    check("clr_in_ready", 64'(in_ready), 64'd1);
    check("clr_done", 64'(done), 64'd0);

    // Address wrap on the AW=8, BASE_ADDR=0xFC instance
    do_clear();
    check("wrap_base", 64'(w_wr_addr), 64'hFC);
    wr_ready = 1'b1;
    send(2'b00, 6'h0, 4'h0, 4'h0, 12'h0AA, 24'h0, 1'b0);
    send(2'b00, 6'h0, 4'h0, 4'h0, 12'h0BB, 24'h0, 1'b1);
    wait_done();
    check("wrap_done", 64'(w_done), 64'd1);
    check("wrap_addr_end", 64'(w_wr_addr), 64'h04);
    check("wrap_nlog", 64'(wlog_w.size()), 64'd2);
    if (wlog_w.size() == 2) begin
      check("wrap_w0", wlog_w[0], {32'hFC, 32'hE00000AA});
      check("wrap_w1", wlog_w[1], {32'h00, 32'hE00000BB});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Reverse of the core's instruction decoder: accepts field-level instruction descriptors and packs them into 32-bit ARM machine words, using the same field split as the decoder (Op, Funct, Rn, Rd, Src2 / imm24).
- Buffers encoded words in a small FIFO and streams them into instruction memory at incrementing word addresses.
- Used as the program loader in front of the single-cycle core's imem, for self-checking benches and boot-time program loading.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- AW, 32, instruction-memory address width.
- BASE_ADDR, 0, first write address after reset or clear (word aligned).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- clear  input  1  synchronous restart; same effect as reset.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  encoder can accept a descriptor.
- in_op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- in_cond  input  4  condition field, instr[31:28].
- in_funct  input  6  instr[25:20] for op 00/01; only bit 4 (L) is used for op 10.
- in_rn  input  4  instr[19:16].
- in_rd  input  4  instr[15:12].
- in_src2  input  12  instr[11:0].
- in_imm24  input  24  branch offset, instr[23:0].
- in_last  input  1  final descriptor of the program.
- wr_valid  output  1  a word is presented to imem.
- wr_ready  input  1  imem accepts the word.
- wr_addr  output  AW  byte address of the word.
- wr_data  output  32  encoded word.
- words_written  output  16  count of words accepted by imem; saturates at 0xFFFF.
- err_sticky  output  1  an illegal descriptor was rejected.
- done  output  1  program fully written.

Behaviour:
- Reset (reset=0) or clear=1:
  - FIFO empty; state LOAD; wr_addr=BASE_ADDR; words_written=0; err_sticky=0; done=0; wr_valid=0.
  - Overrides any handshake in the same cycle; queued words are discarded.
- Encoding, by in_op:
  - 00 / 01: {cond, op, funct, rn, rd, src2}.
  - 10: {cond, 2'b10, 1'b1, funct[4], imm24}.
  - No other field checks.
- Accept occurs when in_valid & in_ready.
  - in_op==11 is accepted but not enqueued. err_sticky=1 next cycle. in_last is ignored for that descriptor.
- in_ready = (state==LOAD) & FIFO not full.
  - No bypass: a pop in the same cycle does not open a slot in a full FIFO.
- Latency: an accepted word is visible on wr_data one cycle later at the earliest. The FIFO is registered, with no combinational in-to-wr path.
- wr_valid = FIFO not empty. wr_data = head entry. wr_addr = address counter.
- wr_valid and wr_data stay stable while wr_ready=0.
- Pop occurs when wr_valid & wr_ready:
  - address counter += 4, wrapping mod 2^AW;
  - words_written += 1, saturating.
- Simultaneous push and pop with the FIFO neither full nor empty: occupancy unchanged; order preserved.
- Each FIFO entry stores {last, word}.
- State machine:
  - LOAD: a legal descriptor accepted with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. Popping the entry whose last bit is set moves to DONE.
  - DONE: done=1, in_ready=0, wr_valid=0. Holds until reset or clear.
- err_sticky does not block operation; it clears only on reset or clear.

Test Plan:
- ADD R1,R2,#5: op=00, cond=E, funct=101000, rn=2, rd=1, src2=005, wr_ready=1 -> one cycle later wr_valid=1, wr_data=0xE2821005, wr_addr=0x0. Next cycle words_written=1.
- LDR R3,[R4,#8] then BL +0x10: first descriptor op=01, funct=011001, rn=4, rd=3, src2=008; second descriptor op=10, funct[4]=1, imm24=0x000010, last=1 -> wr_data 0xE5943008 @0x0, then 0xEB000010 @0x4. done=1 in the cycle after the second pop; in_ready=0 afterwards.
- Backpressure: wr_ready=0, offer 5 descriptors back-to-back -> in_ready drops after 4 accepts. Raise wr_ready -> words at 0x0, 0x4, 0x8, 0xC in order; the 5th is then accepted and written at 0x10.
- Illegal op=11 between two legal words -> err_sticky=1. Only 2 words are written, at 0x0 and 0x4; words_written=2.
- clear asserted while 3 words are queued and wr_ready=0 -> next cycle wr_valid=0, wr_addr=BASE_ADDR, words_written=0, state LOAD, err_sticky=0.
- Address wrap with AW=8, BASE_ADDR=0xFC, two words -> addresses 0xFC then 0x00.
